register_file_unit: RTL

REGISTER_FILE_UNIT -- requirements
Module: register_file_unit

---
 rtl/register_file_unit.sv | 96 +++++++++
 1 files changed

// File: rtl/register_file_unit.sv
// Register file unit: four general (R1-R4) and four scratch (S1-S4) registers
// sharing one load bus and one function select, with two combinational read ports.
module register_file_unit #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [3:0]       RegSel,
  input  logic [3:0]       ScrSel,
  input  logic [2:0]       OutASel,
  input  logic [2:0]       OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  localparam int NREG = 8;

  typedef enum logic [2:0] {
    FN_DEC  = 3'b000,
    FN_INC  = 3'b001,
    FN_LOAD = 3'b010,
    FN_CLR  = 3'b011,
    FN_LOZ  = 3'b100,
    FN_LOW  = 3'b101,
    FN_HIW  = 3'b110,
    FN_SEXT = 3'b111
  } fun_t;

  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] nxt  [NREG];
  logic [NREG-1:0]  en;
  logic [WIDTH-1:0] lo_ext;
  logic [WIDTH-1:0] sx_ext;
  fun_t             fun;

  // index 0..3 = R1..R4, 4..7 = S1..S4, matching the read select encoding
  assign en = {ScrSel[0], ScrSel[1], ScrSel[2], ScrSel[3],
               RegSel[0], RegSel[1], RegSel[2], RegSel[3]};

  assign fun    = fun_t'(FunSel);
  assign lo_ext = WIDTH'(I[7:0]);
  assign sx_ext = WIDTH'($signed(I[7:0]));

  function automatic logic [WIDTH-1:0] apply_fun(
    input fun_t             f,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] din,
    input logic [WIDTH-1:0] lz,
    input logic [WIDTH-1:0] sx
  );
    logic [WIDTH-1:0] r;
    r = cur;
    unique case (f)
      FN_DEC:  r = cur - 1'b1;
      FN_INC:  r = cur + 1'b1;
      FN_LOAD: r = din;
      FN_CLR:  r = '0;
      FN_LOZ:  r = lz;
      FN_LOW:  r = {cur[WIDTH-1:8], lz[7:0]};
      FN_HIW:  r = {lz[WIDTH-9:0], cur[7:0]};
      FN_SEXT: r = sx;
      default: r = cur;
    endcase
    return r;
  endfunction

  // each register computes from its own value so parallel ops stay independent
  always_comb begin
    for (int k = 0; k < NREG; k++) begin
      nxt[k] = regs[k];
      if (en[k]) begin
        nxt[k] = apply_fun(fun, regs[k], I, lo_ext, sx_ext);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int k = 0; k < NREG; k++) begin
        regs[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (en[k]) begin
          regs[k] <= nxt[k];
        end
      end
    end
  end

  assign OutA = regs[OutASel];
  assign OutB = regs[OutBSel];

endmodule
